// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Holds the FSM state and requester-id enums plus the access beat widths.
// Imported by the interface and the arbiter so both agree on word sizes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  localparam int INSTR_BYTES = 4;
  localparam int DATA_BYTES  = 8;

  // The memory beat is big-endian, so the bytes at addr..addr+3 sit in the top half.
  function automatic logic [INSTR_BYTES*8-1:0] instr_word(input logic [DATA_BYTES*8-1:0] beat);
    return beat[DATA_BYTES*8-1 -: INSTR_BYTES*8];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port.
// The slave modport is the arbiter; the master modport is the
// requesters together with the memory that returns read data.
interface mem_port_arbiter_if #(
  parameter int AW = 64
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [63:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [63:0]   d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory, one access in flight.
// Latency: gnt/mem_en combinational in IDLE; rvalid exactly MEM_LAT cycles after gnt.
// Backpressure: requesters hold req until gnt; no grant while busy or in the rvalid cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 64
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int            CW       = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  req_id_e                   last_gnt_q, last_gnt_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic                      we_q, we_d;
  logic [DATA_BYTES*8-1:0]   wdata_q, wdata_d;
  logic [INSTR_BYTES*8-1:0]  if_rdata_q, if_rdata_d, if_rdata_c;
  logic [DATA_BYTES*8-1:0]   d_rdata_q, d_rdata_d, d_rdata_c;

  logic can_grant;
  logic grant_data;
  logic grant_fetch;
  logic fetch_done;
  logic data_done;

  // Grant only from IDLE and never while reset is held; on conflict the side not granted last wins.
  always_comb begin
    can_grant   = (state_q == IDLE) && !reset;
    grant_data  = can_grant && bus.d_req && (!bus.if_req || (last_gnt_q == REQ_I));
    grant_fetch = can_grant && bus.if_req && !grant_data;
    fetch_done  = (state_q == BUSY_I) && (cnt_q == '0);
    data_done   = (state_q == BUSY_D) && (cnt_q == '0);
    if_rdata_c  = fetch_done ? instr_word(bus.mem_rdata) : if_rdata_q;
    d_rdata_c   = data_done ? (we_q ? '0 : bus.mem_rdata) : d_rdata_q;
  end

  // The grant cycle forwards the request straight to memory; afterwards the latched copy holds it.
  always_comb begin
    bus.if_gnt    = grant_fetch;
    bus.d_gnt     = grant_data;
    bus.mem_en    = grant_fetch || grant_data;
    bus.mem_addr  = grant_data ? bus.d_addr : (grant_fetch ? bus.if_addr : addr_q);
    bus.mem_we    = grant_data ? bus.d_we : (grant_fetch ? 1'b0 : we_q);
    bus.mem_wdata = grant_data ? bus.d_wdata : (grant_fetch ? '0 : wdata_q);
    bus.if_rvalid = fetch_done;
    bus.d_rvalid  = data_done;
    bus.if_rdata  = if_rdata_c;
    bus.d_rdata   = d_rdata_c;
  end

  // Next-state: latch the granted request, count down the access, return to IDLE on completion.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_c;
    d_rdata_d  = d_rdata_c;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d    = BUSY_D;
          cnt_d      = CNT_LOAD;
          last_gnt_d = REQ_D;
          addr_d     = bus.d_addr;
          we_d       = bus.d_we;
          wdata_d    = bus.d_wdata;
        end else if (grant_fetch) begin
          state_d    = BUSY_I;
          cnt_d      = CNT_LOAD;
          last_gnt_d = REQ_I;
          addr_d     = bus.if_addr;
          we_d       = 1'b0;
          wdata_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All arbiter state; reset abandons any access in flight so it never completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= REQ_I;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at MEM_LAT=2, one at MEM_LAT=1.
// A transaction-level model checks every output every cycle; directed tests
// add literal expectations on grant/completion order, timing and data.
module tb_mem_port_arbiter;

  typedef struct {
    logic        ig, irv, dg, drv, me, mw;
    logic [31:0] ird;
    logic [63:0] drd, ma, mwd;
  } obs_t;

  typedef struct {
    int          cyc;
    int          who;
    logic [63:0] dat;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(64)) bus0();
  mem_port_arbiter_if #(.AW(64)) bus1();

  mem_port_arbiter #(.MEM_LAT(2), .AW(64)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  mem_port_arbiter #(.MEM_LAT(1), .AW(64)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  logic        s_if_req  [2];
  logic [63:0] s_if_addr [2];
  logic        s_d_req   [2];
  logic        s_d_we    [2];
  logic [63:0] s_d_addr  [2];
  logic [63:0] s_d_wdata [2];
  logic [63:0] s_mem_rd  [2];

  assign bus0.if_req    = s_if_req[0];
  assign bus0.if_addr   = s_if_addr[0];
  assign bus0.d_req     = s_d_req[0];
  assign bus0.d_we      = s_d_we[0];
  assign bus0.d_addr    = s_d_addr[0];
  assign bus0.d_wdata   = s_d_wdata[0];
  assign bus0.mem_rdata = s_mem_rd[0];
  assign bus1.if_req    = s_if_req[1];
  assign bus1.if_addr   = s_if_addr[1];
  assign bus1.d_req     = s_d_req[1];
  assign bus1.d_we      = s_d_we[1];
  assign bus1.d_addr    = s_d_addr[1];
  assign bus1.d_wdata   = s_d_wdata[1];
  assign bus1.mem_rdata = s_mem_rd[1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat [2] = '{2, 1};

  // transaction model: one access in flight with a due cycle
  bit          m_busy [2];
  int          m_due  [2];
  int          m_own  [2];
  int          m_last [2];
  logic [63:0] m_addr [2];
  logic        m_we   [2];
  logic [63:0] m_wd   [2];
  logic [31:0] m_ird  [2];
  logic [63:0] m_drd  [2];

  // memory image and its single pending response per instance
  logic [63:0] mem_img [logic [63:0]];
  int          p_due  [2] = '{-1, -1};
  logic [63:0] p_addr [2];

  ev_t g0[$], r0[$], g1[$], r1[$];

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
  endfunction

  function automatic ev_t ev_at(input ev_t q[$], input int i);
    ev_t e;
    e.cyc = -999;
    e.who = -1;
    e.dat = '1;
    if (i >= 0 && i < q.size()) e = q[i];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int k, input obs_t o);
    string       p;
    bit          done;
    int          who;
    logic [63:0] ea, ewd, beat;
    logic        ewe;
    p = $sformatf("u%0d@%0d", k, cyc);
    if (reset) begin
      chk({p, " rst if_gnt"}, 64'(o.ig), 0);
      chk({p, " rst d_gnt"}, 64'(o.dg), 0);
      chk({p, " rst mem_en"}, 64'(o.me), 0);
      chk({p, " rst mem_we"}, 64'(o.mw), 0);
      chk({p, " rst if_rvalid"}, 64'(o.irv), 0);
      chk({p, " rst d_rvalid"}, 64'(o.drv), 0);
      chk({p, " rst if_rdata"}, 64'(o.ird), 0);
      chk({p, " rst d_rdata"}, o.drd, 0);
      chk({p, " rst mem_addr"}, o.ma, 0);
      chk({p, " rst mem_wdata"}, o.mwd, 0);
      m_busy[k] = 0; m_last[k] = 0; m_addr[k] = '0; m_we[k] = 0; m_wd[k] = '0;
      m_ird[k] = '0; m_drd[k] = '0; p_due[k] = -1;
      return;
    end
    done = m_busy[k] && (cyc == m_due[k]);
    if (done && m_own[k] == 0) begin
      beat = mem_val(m_addr[k]);
      m_ird[k] = beat[63:32];
    end
    if (done && m_own[k] == 1) m_drd[k] = m_we[k] ? 64'd0 : mem_val(m_addr[k]);
    who = -1;
    if (!m_busy[k]) begin
      if (s_if_req[k] && s_d_req[k]) who = (m_last[k] == 0) ? 1 : 0;
      else if (s_if_req[k])          who = 0;
      else if (s_d_req[k])           who = 1;
    end
    ea = m_addr[k]; ewe = m_we[k]; ewd = m_wd[k];
    if (who == 0) begin ea = s_if_addr[k]; ewe = 0; ewd = '0; end
    if (who == 1) begin ea = s_d_addr[k]; ewe = s_d_we[k]; ewd = s_d_wdata[k]; end
    chk({p, " if_gnt"}, 64'(o.ig), 64'(who == 0));
    chk({p, " d_gnt"}, 64'(o.dg), 64'(who == 1));
    chk({p, " mem_en"}, 64'(o.me), 64'(who >= 0));
    chk({p, " if_rvalid"}, 64'(o.irv), 64'(done && m_own[k] == 0));
    chk({p, " d_rvalid"}, 64'(o.drv), 64'(done && m_own[k] == 1));
    chk({p, " if_rdata"}, 64'(o.ird), 64'(m_ird[k]));
    chk({p, " d_rdata"}, o.drd, m_drd[k]);
    chk({p, " mem_addr"}, o.ma, ea);
    chk({p, " mem_wdata"}, o.mwd, ewd);
    if (who >= 0 || m_busy[k]) chk({p, " mem_we"}, 64'(o.mw), 64'(ewe));
    if (k == 0) begin
      if (o.ig)  g0.push_back('{cyc, 0, 64'd0});
      if (o.dg)  g0.push_back('{cyc, 1, 64'd0});
      if (o.irv) r0.push_back('{cyc, 0, 64'(o.ird)});
      if (o.drv) r0.push_back('{cyc, 1, o.drd});
    end else begin
      if (o.ig)  g1.push_back('{cyc, 0, 64'd0});
      if (o.dg)  g1.push_back('{cyc, 1, 64'd0});
      if (o.irv) r1.push_back('{cyc, 0, 64'(o.ird)});
      if (o.drv) r1.push_back('{cyc, 1, o.drd});
    end
    if (done) m_busy[k] = 0;
    if (who >= 0) begin
      m_busy[k] = 1; m_due[k] = cyc + lat[k]; m_own[k] = who; m_last[k] = who;
      m_addr[k] = ea; m_we[k] = ewe; m_wd[k] = ewd;
    end
    if (o.me) begin p_due[k] = cyc + lat[k]; p_addr[k] = o.ma; end
  endtask

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    obs_t o;
    o.ig = bus0.if_gnt; o.irv = bus0.if_rvalid; o.ird = bus0.if_rdata;
    o.dg = bus0.d_gnt;  o.drv = bus0.d_rvalid;  o.drd = bus0.d_rdata;
    o.me = bus0.mem_en; o.mw = bus0.mem_we; o.ma = bus0.mem_addr; o.mwd = bus0.mem_wdata;
    step(0, o);
    o.ig = bus1.if_gnt; o.irv = bus1.if_rvalid; o.ird = bus1.if_rdata;
    o.dg = bus1.d_gnt;  o.drv = bus1.d_rvalid;  o.drd = bus1.d_rdata;
    o.me = bus1.mem_en; o.mw = bus1.mem_we; o.ma = bus1.mem_addr; o.mwd = bus1.mem_wdata;
    step(1, o);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // memory returns the beat exactly MEM_LAT cycles after mem_en, junk otherwise
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++)
      s_mem_rd[k] = (cyc == p_due[k]) ? mem_val(p_addr[k]) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    g0.delete(); r0.delete(); g1.delete(); r1.delete();
  endtask

  initial begin
    int c0, c1;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_if_req[k] = 0; s_if_addr[k] = '0; s_d_req[k] = 0; s_d_we[k] = 0;
      s_d_addr[k] = '0; s_d_wdata[k] = '0; s_mem_rd[k] = '0;
    end
    mem_img[64'h2000] = 64'hDEADBEEF_00000000;
    mem_img[64'h40]   = 64'hCAFEF00D_12345678;
    mem_img[64'h100]  = 64'h0102030405060708;
    mem_img[64'h108]  = 64'hA1A2A3A4A5A6A7A8;
    tick(3);
    reset = 1'b0;
    tick(2);

    // single fetch
    clear_logs();
    c0 = cyc;
    s_if_req[0] = 1; s_if_addr[0] = 64'h2000;
    tick(1);
    s_if_req[0] = 0;
    tick(4);
    chk("fetch gnt count", 64'(g0.size()), 1);
    chk("fetch gnt cycle", 64'(ev_at(g0, 0).cyc - c0), 0);
    chk("fetch rvalid cycle", 64'(ev_at(r0, 0).cyc - c0), 2);
    chk("fetch rdata", ev_at(r0, 0).dat, 64'hDEADBEEF);

    // load to give d_rdata a non-zero value
    clear_logs();
    s_d_req[0] = 1; s_d_we[0] = 0; s_d_addr[0] = 64'h40;
    tick(1);
    s_d_req[0] = 0;
    tick(3);
    chk("load rdata", ev_at(r0, 0).dat, 64'hCAFEF00D_12345678);

    // store
    clear_logs();
    c0 = cyc;
    s_d_req[0] = 1; s_d_we[0] = 1; s_d_addr[0] = 64'h10000; s_d_wdata[0] = 64'h1122334455667788;
    tick(1);
    s_d_req[0] = 0; s_d_we[0] = 0;
    #1;
    chk("store mem_we held", 64'(bus0.mem_we), 1);
    chk("store mem_wdata held", bus0.mem_wdata, 64'h1122334455667788);
    tick(4);
    chk("store gnt cycle", 64'(ev_at(g0, 0).cyc - c0), 0);
    chk("store rvalid who", 64'(ev_at(r0, 0).who), 1);
    chk("store rvalid cycle", 64'(ev_at(r0, 0).cyc - c0), 2);
    chk("store rdata", ev_at(r0, 0).dat, 64'd0);
    chk("store completions", 64'(r0.size()), 1);

    // conflict from reset: D, I, D, I, three cycles apart
    clear_logs();
    reset = 1'b1;
    s_if_req[0] = 1; s_if_addr[0] = 64'h3000;
    s_d_req[0]  = 1; s_d_addr[0]  = 64'h3800; s_d_we[0] = 0;
    tick(2);
    reset = 1'b0;
    c0 = cyc;
    tick(10);
    s_if_req[0] = 0; s_d_req[0] = 0;
    tick(4);
    chk("conflict gnt count", 64'(g0.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("conflict gnt%0d who", i), 64'(ev_at(g0, i).who), 64'((i % 2 == 0) ? 1 : 0));
      chk($sformatf("conflict gnt%0d cycle", i), 64'(ev_at(g0, i).cyc - c0), 64'(3 * i));
    end
    chk("conflict completions", 64'(r0.size()), 4);

    // reset while the load is one cycle from completing
    clear_logs();
    s_d_req[0] = 1; s_d_we[0] = 0; s_d_addr[0] = 64'h300;
    tick(1);
    s_d_req[0] = 0;
    reset = 1'b1;
    #1;
    chk("abort mem_addr", bus0.mem_addr, 64'd0);
    chk("abort d_rdata", bus0.d_rdata, 64'd0);
    chk("abort d_rvalid", 64'(bus0.d_rvalid), 0);
    tick(2);
    reset = 1'b0;
    tick(3);
    chk("abort no completion", 64'(r0.size()), 0);
    clear_logs();
    c1 = cyc;
    s_if_req[0] = 1; s_if_addr[0] = 64'h600;
    s_d_req[0]  = 1; s_d_addr[0]  = 64'h308;
    tick(1);
    s_d_req[0] = 0;
    tick(3);
    s_if_req[0] = 0;
    tick(4);
    chk("rerequest first who", 64'(ev_at(g0, 0).who), 1);
    chk("rerequest first cycle", 64'(ev_at(g0, 0).cyc - c1), 0);
    chk("rerequest second who", 64'(ev_at(g0, 1).who), 0);
    chk("rerequest second cycle", 64'(ev_at(g0, 1).cyc - c1), 3);

    // one-cycle data request while a fetch is busy
    clear_logs();
    c0 = cyc;
    s_if_req[0] = 1; s_if_addr[0] = 64'h500;
    tick(1);
    s_if_req[0] = 0;
    s_d_req[0] = 1; s_d_addr[0] = 64'h700;
    tick(1);
    s_d_req[0] = 0;
    tick(4);
    chk("glitch gnt count", 64'(g0.size()), 1);
    chk("glitch gnt who", 64'(ev_at(g0, 0).who), 0);
    chk("glitch completions", 64'(r0.size()), 1);
    chk("glitch fetch rvalid cycle", 64'(ev_at(r0, 0).cyc - c0), 2);

    // back-to-back loads at MEM_LAT=1
    clear_logs();
    c0 = cyc;
    s_d_req[1] = 1; s_d_we[1] = 0; s_d_addr[1] = 64'h100;
    tick(1);
    s_d_addr[1] = 64'h108;
    tick(2);
    s_d_req[1] = 0;
    tick(3);
    chk("b2b gnt count", 64'(g1.size()), 2);
    chk("b2b gnt0 cycle", 64'(ev_at(g1, 0).cyc - c0), 0);
    chk("b2b gnt1 cycle", 64'(ev_at(g1, 1).cyc - c0), 2);
    chk("b2b rv0 cycle", 64'(ev_at(r1, 0).cyc - c0), 1);
    chk("b2b rv1 cycle", 64'(ev_at(r1, 1).cyc - c0), 3);
    chk("b2b rv0 data", ev_at(r1, 0).dat, 64'h0102030405060708);
    chk("b2b rv1 data", ev_at(r1, 1).dat, 64'hA1A2A3A4A5A6A7A8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, meaning: cycles from memory access issue to read data valid (legal range 1..15).
REQ-002 Parameter AW, default 64, meaning: address width in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch request; held high until if_gnt.
REQ-006 if_addr  input  AW  fetch byte address; stable while if_req is high.
REQ-007 if_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-008 if_rvalid  output  1  one-cycle pulse: if_rdata is valid.
REQ-009 if_rdata  output  32  fetched instruction word.
REQ-010 d_req  input  1  data load/store request; held high until d_gnt.
REQ-011 d_we  input  1  1 = store, 0 = load; sampled with d_req.
REQ-012 d_addr  input  AW  data byte address; stable while d_req is high.
REQ-013 d_wdata  input  64  store data.
REQ-014 d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-015 d_rvalid  output  1  one-cycle pulse: load data valid, or store complete.
REQ-016 d_rdata  output  64  load data; 0 on store completion.
REQ-017 mem_en  output  1  one-cycle access strobe to the shared memory.
REQ-018 mem_we  output  1  write qualifier, valid only with mem_en.
REQ-019 mem_addr  output  AW  memory byte address, held for the whole access.
REQ-020 mem_wdata  output  64  memory write data, held for the whole access.
REQ-021 mem_rdata  input  64  8-byte big-endian read data from memory, valid MEM_LAT cycles after mem_en.

Function
REQ-022 FSM states: IDLE, BUSY_I, BUSY_D; exactly one access is outstanding at any time.
REQ-023 In IDLE with exactly one request pending: assert that requester's gnt and mem_en in the same (combinational) cycle; at the edge, latch address/data/we and enter BUSY_I or BUSY_D.
REQ-024 In IDLE with both requests pending: grant the requester that was not granted last.
  - A last_gnt flag records the last grant and resets to "instruction", so data wins the first conflict after reset.
REQ-025 mem_addr, mem_we and mem_wdata are registered copies of the granted request, stable from grant until the access completes.
REQ-026 A down-counter loads MEM_LAT-1 at grant and decrements once per BUSY cycle.
REQ-027 In the BUSY cycle where the counter is 0: pulse the matching rvalid, drive the rdata, and return to IDLE.
REQ-028 Grant-to-rvalid latency is exactly MEM_LAT cycles, i.e. rvalid is asserted in cycle grant+MEM_LAT.
REQ-029 No grant is issued in a BUSY state, nor in the cycle rvalid is asserted; a new grant is possible at the earliest one cycle after rvalid.
REQ-030 if_rdata = mem_rdata[63:32] (bytes addr..addr+3), registered at completion and held until the next fetch completion.
REQ-031 d_rdata = mem_rdata for a load and 0 for a store, registered at completion and held until the next data completion.
REQ-032 A store is signalled by mem_we=1 with mem_en; it completes with d_rvalid after MEM_LAT cycles, the same as a load.
REQ-033 Requests that drop before their gnt are ignored; no state change and no grant results.
REQ-034 gnt and rvalid pulses never exceed one cycle, and the two requesters' pulses are never simultaneous.
REQ-035 Addresses are passed through unmodified: no alignment check and no wrap handling; these are the memory's responsibility.

Reset
REQ-036 reset forces state=IDLE, counter=0 and last_gnt=instruction, and sets every output to 0 (including if_rdata, d_rdata, mem_addr and mem_wdata).
REQ-037 A reset asserted during BUSY aborts the access: no rvalid is ever issued for it, and the requester must re-request.
REQ-038 The first grant after reset deassertion may occur on the first rising clk edge at which a request is seen in IDLE.

Structure
REQ-039 A shared package holds the FSM state enum (IDLE/BUSY_I/BUSY_D), the requester-id enum (REQ_I/REQ_D), the constant INSTR_BYTES=4 and the constant DATA_BYTES=8.
REQ-040 The implementation is a single module with no sub-modules; the latency counter is inline.

Verification
REQ-041 Single fetch with MEM_LAT=2: if_req with if_addr=0x2000 and mem_rdata=0xDEADBEEF_00000000 -> if_gnt and mem_en at cycle 0, mem_we=0, if_rvalid at cycle 2 with if_rdata=0xDEADBEEF.
REQ-042 Store: d_req, d_we=1, d_addr=0x10000, d_wdata=0x1122334455667788 -> mem_we=1 and mem_wdata held for 2 cycles, then d_rvalid with d_rdata=0; if_rvalid stays 0 throughout.
REQ-043 Conflict: if_req and d_req held high together from reset -> grants D, I, D, I in that order; each grant is 3 cycles apart (MEM_LAT=2); neither requester is starved.
REQ-044 Back-to-back loads with MEM_LAT=1, d_addr=0x100 then 0x108 -> d_gnt at cycles 0 and 2, and d_rvalid at cycles 1 and 3 with correct data.
REQ-045 Reset mid-access: assert reset in BUSY_D at counter=1 -> all outputs 0 immediately and no d_rvalid; after release, re-issuing d_req is granted normally with data priority.
REQ-046 Glitched request: d_req high for 1 cycle while BUSY_I, then dropped -> no d_gnt, no mem_en for data, and the fetch completes normally.
